// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: memory-wait FSM with timeout, branch flush and data-hazard bubbles.
// Define HAZARD_FWD_EN when forwarding paths exist, so only load-use hazards stall.
module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic        exe_wb_en,
    input  logic        exe_mem_read,
    input  logic [3:0]  exe_dest,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        if_freeze,
    output logic        id_freeze,
    output logic        id_flush,
    output logic        exe_flush,
    output logic        pipe_freeze,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {RUN, WAIT, TOUT} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       src1_exe, src2_exe, hazard, mem_stall;

    assign src1_exe = (id_src1 == exe_dest);
    assign src2_exe = id_two_src && (id_src2 == exe_dest);

`ifdef HAZARD_FWD_EN
    // Forwarding covers everything except a load whose data is not back yet.
    logic unused_fwd;
    assign unused_fwd = ^{mem_dest, mem_wb_en};
    assign hazard = exe_wb_en && exe_mem_read && (src1_exe || src2_exe);
`else
    logic src1_mem, src2_mem;
    logic unused_nofwd;
    assign unused_nofwd = exe_mem_read;
    assign src1_mem = (id_src1 == mem_dest);
    assign src2_mem = id_two_src && (id_src2 == mem_dest);
    assign hazard = (exe_wb_en && (src1_exe || src2_exe)) ||
                    (mem_wb_en && (src1_mem || src2_mem));
`endif

    // The cycle mem_ready rises is never a stall, so the pipeline advances immediately.
    assign mem_stall = !mem_ready && (mem_req || state != RUN);

    always_comb begin
        state_nxt   = state;
        if_freeze   = 1'b0;
        id_freeze   = 1'b0;
        id_flush    = 1'b0;
        exe_flush   = 1'b0;
        pipe_freeze = 1'b0;

        case (state)
            RUN:  if (mem_req && !mem_ready) state_nxt = WAIT;
            WAIT: begin
                if (mem_ready)                    state_nxt = RUN;
                else if (wait_cnt == WAIT_LIMIT)  state_nxt = TOUT;
            end
            TOUT: if (mem_ready) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        // Priority: memory stall, then taken branch, then data hazard; all held low in reset.
        if (!rst) begin
            if (mem_stall) begin
                if_freeze   = 1'b1;
                id_freeze   = 1'b1;
                pipe_freeze = 1'b1;
            end else if (branch_taken) begin
                id_flush  = 1'b1;
                exe_flush = 1'b1;
            end else if (hazard) begin
                if_freeze = 1'b1;
                id_freeze = 1'b1;
                exe_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt == WAIT && state != WAIT)
                wait_cnt <= 8'd0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 8'd1;
            if (state_nxt == TOUT && state != TOUT)
                mem_timeout <= 1'b1;
            if (if_freeze && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; expected values follow the build's HAZARD_FWD_EN setting.
module tb_hazard_stall_ctrl;

    localparam int MAXW = 4;
    // {if_freeze, id_freeze, pipe_freeze, id_flush, exe_flush}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] HAZ  = 5'b11001;
    localparam logic [4:0] MEMS = 5'b11100;
    localparam logic [4:0] BRN  = 5'b00011;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic        branch_taken, mem_req, mem_ready;
    logic        if_freeze, id_freeze, id_flush, exe_flush, pipe_freeze, mem_timeout;
    logic [15:0] stall_count;

    int vectors = 0;
    int errors  = 0;

    wire [4:0] ctl = {if_freeze, id_freeze, pipe_freeze, id_flush, exe_flush};

    hazard_stall_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .if_freeze(if_freeze), .id_freeze(id_freeze), .id_flush(id_flush),
        .exe_flush(exe_flush), .pipe_freeze(pipe_freeze),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_FWD_EN
    localparam logic [4:0] HAZ_NOLOAD = NONE;
`else
    localparam logic [4:0] HAZ_NOLOAD = HAZ;
`endif

    task automatic idle();
        id_src1 = 4'd1; id_src2 = 4'd2; id_two_src = 1'b0;
        exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = 4'd9;
        mem_wb_en = 1'b0; mem_dest = 4'd10;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        exe_wb_en = 1'b1; exe_dest = 4'd1; mem_req = 1'b1; branch_taken = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL reset_ctl got=%b want=%b", ctl, NONE); end
        vectors++;
        if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", stall_count); end
        vectors++;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_tout got=%b want=0", mem_timeout); end
        idle();
        @(negedge clk); rst = 1'b0;
        #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL reset_release got=%b want=%b", ctl, NONE); end
    endtask

    task automatic test_exe_hazard();
        @(negedge clk); idle();
        exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3; #1;
        vectors++;
        if (ctl !== HAZ_NOLOAD) begin errors++; $display("FAIL exe_noload got=%b want=%b", ctl, HAZ_NOLOAD); end
        exe_mem_read = 1'b1; #1;
        vectors++;
        if (ctl !== HAZ) begin errors++; $display("FAIL exe_load got=%b want=%b", ctl, HAZ); end
        exe_wb_en = 1'b0; #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL exe_nowb got=%b want=%b", ctl, NONE); end
        exe_wb_en = 1'b1; exe_mem_read = 1'b0; exe_dest = 4'd0; id_src1 = 4'd0; #1;
        vectors++;
        if (ctl !== HAZ_NOLOAD) begin errors++; $display("FAIL exe_reg0 got=%b want=%b", ctl, HAZ_NOLOAD); end
    endtask

    task automatic test_src2();
        @(negedge clk); idle();
        id_src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1; id_two_src = 1'b0; #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL src2_unused got=%b want=%b", ctl, NONE); end
        id_two_src = 1'b1; #1;
        vectors++;
        if (ctl !== HAZ_NOLOAD) begin errors++; $display("FAIL src2_mem got=%b want=%b", ctl, HAZ_NOLOAD); end
        mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd5; #1;
        vectors++;
        if (ctl !== HAZ) begin errors++; $display("FAIL src2_load got=%b want=%b", ctl, HAZ); end
    endtask

    task automatic test_branch();
        @(negedge clk); idle();
        exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd1; branch_taken = 1'b1; #1;
        vectors++;
        if (ctl !== BRN) begin errors++; $display("FAIL branch_over_haz got=%b want=%b", ctl, BRN); end
        exe_wb_en = 1'b0; #1;
        vectors++;
        if (ctl !== BRN) begin errors++; $display("FAIL branch_only got=%b want=%b", ctl, BRN); end
    endtask

    task automatic test_mem_wait();
        reset_pulse();
        idle();
        mem_req = 1'b1; #1;
        vectors++;
        if (ctl !== MEMS) begin errors++; $display("FAIL wait_c0 got=%b want=%b", ctl, MEMS); end
        @(negedge clk); branch_taken = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd1; #1;
        vectors++;
        if (ctl !== MEMS) begin errors++; $display("FAIL wait_branch got=%b want=%b", ctl, MEMS); end
        @(negedge clk); branch_taken = 1'b0; exe_wb_en = 1'b0; #1;
        vectors++;
        if (ctl !== MEMS) begin errors++; $display("FAIL wait_c2 got=%b want=%b", ctl, MEMS); end
        @(negedge clk); mem_ready = 1'b1; #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL wait_ready got=%b want=%b", ctl, NONE); end
        vectors++;
        if (stall_count !== 16'd3) begin errors++; $display("FAIL wait_cnt got=%0d want=3", stall_count); end
        @(negedge clk); mem_req = 1'b0; mem_ready = 1'b0; #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL wait_run got=%b want=%b", ctl, NONE); end
        vectors++;
        if (stall_count !== 16'd3) begin errors++; $display("FAIL wait_cnt_hold got=%0d want=3", stall_count); end
    endtask

    task automatic test_timeout();
        int edges;
        reset_pulse();
        idle();
        mem_req = 1'b1;
        edges = 0;
        while (mem_timeout !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        #1;
        vectors++;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tout_set got=%b want=1 after %0d cycles", mem_timeout, edges); end
        vectors++;
        if (edges <= MAXW) begin errors++; $display("FAIL tout_early got=%0d cycles want>%0d", edges, MAXW); end
        vectors++;
        if (ctl !== MEMS) begin errors++; $display("FAIL tout_ctl got=%b want=%b", ctl, MEMS); end
        mem_req = 1'b0; #1;
        vectors++;
        if (ctl !== MEMS) begin errors++; $display("FAIL tout_noreq got=%b want=%b", ctl, MEMS); end
        @(negedge clk); mem_ready = 1'b1; #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL tout_ready got=%b want=%b", ctl, NONE); end
        @(negedge clk); mem_ready = 1'b0; #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL tout_run got=%b want=%b", ctl, NONE); end
        vectors++;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tout_sticky got=%b want=1", mem_timeout); end
        // enter WAIT again, then reset mid-wait
        mem_req = 1'b1;
        repeat (2) @(negedge clk);
        mem_req = 1'b0; #2;
        rst = 1'b1; #1;
        vectors++;
        if ({ctl, mem_timeout} !== 6'b0) begin errors++; $display("FAIL rst_outs got=%b want=0", {ctl, mem_timeout}); end
        vectors++;
        if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d want=0", stall_count); end
        @(negedge clk); rst = 1'b0; #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL rst_abort got=%b want=%b", ctl, NONE); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); idle();
        exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd1; #1;
        vectors++;
        if (ctl !== HAZ) begin errors++; $display("FAIL b2b_haz got=%b want=%b", ctl, HAZ); end
        @(negedge clk); branch_taken = 1'b1; #1;
        vectors++;
        if (ctl !== BRN) begin errors++; $display("FAIL b2b_brn got=%b want=%b", ctl, BRN); end
        @(negedge clk); idle(); #1;
        vectors++;
        if (ctl !== NONE) begin errors++; $display("FAIL b2b_none got=%b want=%b", ctl, NONE); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_exe_hazard();
        test_src2();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
